idu_stage: RTL and testbench
============================

Name: idu_stage

Overview:
- Registered instruction-decode pipeline stage between IFU and EXU, with valid/ready handshakes on both sides.
- Decodes RV32I/M plus the Zicsr subset (csrrw, csrrs), ecall, mret and ebreak into a control bundle.
- Adds what the combinational decoder lacks: a 2-entry skid buffer for full throughput, a flush input, illegal-instruction detection, and XLEN-parametrised immediates and PC.

Parameters:
XLEN, 32, datapath width; immediates are sign-extended to XLEN, and pc is XLEN wide.
ALUOP_W, 5, width of alu_op; encodings are the team's shared ALU op macros, unchanged.
CSR_IDX_W, 2, width of csr_idx.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
flush  in  1  drop all held and incoming entries this cycle
in_valid  in  1  IFU has an instruction
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  its PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts
out_pc  out  XLEN  PC of the bundle
out_rs1, out_rs2, out_rd  out  5 each  register indices (inst[19:15], [24:20], [11:7])
out_imm  out  XLEN  selected immediate (I/U/S/J/B sign-extended; CSR address zero-extended)
out_alu_op  out  ALUOP_W  ALU operation
out_src1_pc  out  1  src1 is PC (auipc, jal)
out_src2_imm  out  1  src2 is imm
out_pc_op  out  2  0 seq, 1 branch/jal, 2 jalr, 3 trap/mret
out_wd_op  out  2  0 alu, 1 load, 2 pc+4, 3 csr
out_mem_ren, out_mem_wen  out  1 each  load / store
out_mem_size  out  2  funct3[1:0]
out_load_signed  out  1  !funct3[2]
out_rf_wen  out  1  writes rd (forced 0 when rd==0)
out_csr_wen  out  1  csrrw/csrrs/ecall
out_csr_idx  out  CSR_IDX_W  mcause=0, mepc=1, mstatus=2, mtvec=3
out_ecall, out_mret, out_ebreak, out_illegal  out  1 each  special instructions

Behaviour:
- Reset (rst_n low at a clk edge):
  - main and skid entries invalid, so out_valid=0 and in_ready=1.
  - Every bundle output is 0.
  - Reset mid-transfer discards both entries.
- Decode is combinational from in_inst and is captured together with in_pc.
- Latency: an instruction accepted at edge N is presented on out_* after edge N, i.e. in cycle N+1.
- Handshake:
  - A transfer occurs on a side when valid&ready are both high at a clk edge.
  - in_ready = !skid_valid, registered; no combinational path from out_ready.
  - While out_valid=1 and out_ready=0, out_* are held stable.
- Storage rules, applied at each edge:
  - Main empty or draining, skid empty: an incoming instruction goes to main.
  - Main full, not draining, incoming accepted: the instruction goes to skid, so in_ready falls next cycle.
  - Main drains while skid is full: skid moves to main.
  - Main drains, skid is empty, and an instruction arrives in the same cycle: it goes directly to main, so sustained throughput is 1 per cycle.
- flush has priority over everything:
  - Both entries become invalid at that edge, and any in_valid that cycle is dropped.
  - out_valid=0 and in_ready=1 on the next cycle.
- out_illegal=1, with out_rf_wen, out_mem_*, out_csr_wen and out_pc_op all 0, when any of these holds:
  - the opcode is not in the supported set;
  - R-type funct7 is not 0000000, 0100000 or 0000001, or 0100000 is paired with a funct3 other than 000/101;
  - opcode 1110011 with funct3 not in {000, 001, 010}, or funct3=000 with a word other than ecall/mret/ebreak;
  - the CSR address is not 0x342/0x341/0x300/0x305.
- Mapping of csr_idx and pc_op for special instructions:
  - ecall gives csr_idx=3 and pc_op=3; mret gives csr_idx=1 and pc_op=3.
  - ebreak gives pc_op=0 and out_ebreak=1.
- Stores and branches have out_rf_wen=0.
- Immediates are computed at XLEN, then sign-extended from the instruction's top bit; U-type is imm[31:12]<<12 then sign-extended.

Test Plan:
1. Reset, then addi x1,x0,-1 (0xFFF00093) at pc 0x80000000 with out_ready=1 → next cycle: out_valid=1, out_imm=0xFFFFFFFF, out_rd=1, out_rf_wen=1, out_src2_imm=1.
2. Back-to-back stream of 8 instructions with out_ready=1 → 8 outputs on 8 consecutive cycles, in order, in_ready constantly 1.
3. out_ready=0 while two instructions are offered:
   - both accepted, then in_ready=0 and the third is held off;
   - out_* stay stable;
   - raising out_ready drains the two in order, and in_ready returns to 1 one cycle after the first drain.
4. With both entries full, assert flush together with in_valid → next cycle: out_valid=0, in_ready=1; neither entry nor the flush-cycle instruction is ever output.
5. Special and illegal decodes:
   - csrrw on 0x305 → csr_idx=3, wd_op=3, csr_wen=1;
   - ecall (0x00000073) → pc_op=3, csr_idx=3;
   - mret (0x30200073) → pc_op=3, csr_idx=1;
   - 0xFFFFFFFF → out_illegal=1, with all write enables 0.
6. XLEN=64 build: jal x1,-4 (0xFFDFF0EF) → out_imm=0xFFFFFFFFFFFFFFFC, pc_op=1, wd_op=2.

Source files
------------

// File: rtl/idu_stage.sv
// Instruction-decode pipeline stage: RV32I/M + csrrw/csrrs/ecall/mret/ebreak
// decoder feeding a two-entry (main + skid) registered output buffer with
// valid/ready handshakes on both sides.
module idu_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUOP_W   = 5,
  parameter int unsigned CSR_IDX_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_in_inst,
  input  logic [XLEN-1:0]      i_in_pc,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [XLEN-1:0]      o_out_pc,
  output logic [4:0]           o_out_rs1,
  output logic [4:0]           o_out_rs2,
  output logic [4:0]           o_out_rd,
  output logic [XLEN-1:0]      o_out_imm,
  output logic [ALUOP_W-1:0]   o_out_alu_op,
  output logic                 o_out_src1_pc,
  output logic                 o_out_src2_imm,
  output logic [1:0]           o_out_pc_op,
  output logic [1:0]           o_out_wd_op,
  output logic                 o_out_mem_ren,
  output logic                 o_out_mem_wen,
  output logic [1:0]           o_out_mem_size,
  output logic                 o_out_load_signed,
  output logic                 o_out_rf_wen,
  output logic                 o_out_csr_wen,
  output logic [CSR_IDX_W-1:0] o_out_csr_idx,
  output logic                 o_out_ecall,
  output logic                 o_out_mret,
  output logic                 o_out_ebreak,
  output logic                 o_out_illegal
);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_MUL   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(18);
  localparam logic [ALUOP_W-1:0] ALU_EQ    = ALUOP_W'(19);
  localparam logic [ALUOP_W-1:0] ALU_NE    = ALUOP_W'(20);
  localparam logic [ALUOP_W-1:0] ALU_GE    = ALUOP_W'(21);
  localparam logic [ALUOP_W-1:0] ALU_GEU   = ALUOP_W'(22);
  localparam logic [ALUOP_W-1:0] ALU_PASS1 = ALUOP_W'(23);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [XLEN-1:0]      imm;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 src1_pc;
    logic                 src2_imm;
    logic [1:0]           pc_op;
    logic [1:0]           wd_op;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [1:0]           mem_size;
    logic                 load_signed;
    logic                 rf_wen;
    logic                 csr_wen;
    logic [CSR_IDX_W-1:0] csr_idx;
    logic                 ecall;
    logic                 mret;
    logic                 ebreak;
    logic                 illegal;
  } bundle_t;

  // Integer ALU op for funct3, alt selects sub/sra.
  function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic signed [31:0] w_imm_i;
  logic signed [31:0] w_imm_s;
  logic signed [31:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [31:0] w_imm_j;
  logic               w_legal;
  logic               w_writes;
  bundle_t            w_dec;
  logic               w_drain;
  logic               w_accept;

  bundle_t r_main;
  bundle_t r_skid;
  logic    r_main_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  assign w_opc   = i_in_inst[6:0];
  assign w_f3    = i_in_inst[14:12];
  assign w_f7    = i_in_inst[31:25];
  assign w_imm_i = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
  assign w_imm_s = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
  assign w_imm_b = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7], i_in_inst[30:25],
                    i_in_inst[11:8], 1'b0};
  assign w_imm_u = {i_in_inst[31:12], 12'h000};
  assign w_imm_j = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12], i_in_inst[20],
                    i_in_inst[30:21], 1'b0};

  // Combinational decode of the incoming word into a control bundle.
  always_comb begin
    w_dec    = '0;
    w_legal  = 1'b1;
    w_writes = 1'b0;
    w_dec.pc  = i_in_pc;
    w_dec.rs1 = i_in_inst[19:15];
    w_dec.rs2 = i_in_inst[24:20];
    w_dec.rd  = i_in_inst[11:7];
    case (w_opc)
      OPC_LUI: begin
        w_dec.imm = XLEN'(w_imm_u); w_dec.alu_op = ALU_LUI;
        w_dec.src2_imm = 1'b1; w_writes = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.imm = XLEN'(w_imm_u); w_dec.src1_pc = 1'b1;
        w_dec.src2_imm = 1'b1; w_writes = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm = XLEN'(w_imm_j); w_dec.src1_pc = 1'b1; w_dec.src2_imm = 1'b1;
        w_dec.pc_op = 2'd1; w_dec.wd_op = 2'd2; w_writes = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm = XLEN'(w_imm_i); w_dec.src2_imm = 1'b1;
        w_dec.pc_op = 2'd2; w_dec.wd_op = 2'd2; w_writes = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.imm = XLEN'(w_imm_b); w_dec.pc_op = 2'd1;
        case (w_f3)
          3'd0:    w_dec.alu_op = ALU_EQ;
          3'd1:    w_dec.alu_op = ALU_NE;
          3'd4:    w_dec.alu_op = ALU_SLT;
          3'd5:    w_dec.alu_op = ALU_GE;
          3'd6:    w_dec.alu_op = ALU_SLTU;
          3'd7:    w_dec.alu_op = ALU_GEU;
          default: w_dec.alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        w_dec.imm = XLEN'(w_imm_i); w_dec.src2_imm = 1'b1;
        w_dec.wd_op = 2'd1; w_dec.mem_ren = 1'b1; w_writes = 1'b1;
      end
      OPC_STORE: begin
        w_dec.imm = XLEN'(w_imm_s); w_dec.src2_imm = 1'b1; w_dec.mem_wen = 1'b1;
      end
      OPC_OPIMM: begin
        w_dec.imm = XLEN'(w_imm_i); w_dec.src2_imm = 1'b1; w_writes = 1'b1;
        w_dec.alu_op = base_op(w_f3, (w_f3 == 3'd5) && i_in_inst[30]);
      end
      OPC_OP: begin
        w_writes = 1'b1;
        if (w_f7 == 7'b0000001)
          w_dec.alu_op = ALU_MUL + ALUOP_W'(w_f3);
        else if (w_f7 == 7'b0000000)
          w_dec.alu_op = base_op(w_f3, 1'b0);
        else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)))
          w_dec.alu_op = base_op(w_f3, 1'b1);
        else
          w_legal = 1'b0;
      end
      OPC_SYSTEM: begin
        w_dec.imm = XLEN'(i_in_inst[31:20]);
        case (w_f3)
          3'd0: begin
            if (i_in_inst == INST_ECALL) begin
              w_dec.ecall = 1'b1; w_dec.csr_wen = 1'b1;
              w_dec.csr_idx = CSR_IDX_W'(3); w_dec.pc_op = 2'd3;
            end else if (i_in_inst == INST_MRET) begin
              w_dec.mret = 1'b1; w_dec.csr_idx = CSR_IDX_W'(1); w_dec.pc_op = 2'd3;
            end else if (i_in_inst == INST_EBREAK) begin
              w_dec.ebreak = 1'b1;
            end else begin
              w_legal = 1'b0;
            end
          end
          3'd1, 3'd2: begin
            w_dec.alu_op  = (w_f3 == 3'd1) ? ALU_PASS1 : ALU_OR;
            w_dec.wd_op   = 2'd3;
            w_dec.csr_wen = 1'b1;
            w_writes      = 1'b1;
            case (i_in_inst[31:20])
              12'h342: w_dec.csr_idx = CSR_IDX_W'(0);
              12'h341: w_dec.csr_idx = CSR_IDX_W'(1);
              12'h300: w_dec.csr_idx = CSR_IDX_W'(2);
              12'h305: w_dec.csr_idx = CSR_IDX_W'(3);
              default: w_legal = 1'b0;
            endcase
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    w_dec.mem_size    = w_f3[1:0];
    w_dec.load_signed = ~w_f3[2];
    w_dec.rf_wen      = w_writes && (w_dec.rd != 5'd0);
    if (!w_legal) begin
      w_dec.illegal  = 1'b1;
      w_dec.rf_wen   = 1'b0;
      w_dec.mem_ren  = 1'b0;
      w_dec.mem_wen  = 1'b0;
      w_dec.mem_size = 2'd0;
      w_dec.csr_wen  = 1'b0;
      w_dec.pc_op    = 2'd0;
    end
  end

  assign w_drain  = r_main_valid && i_out_ready;
  assign w_accept = i_in_valid && r_in_ready;

  // Main/skid buffer: skid only fills when main is stalled, refills main on drain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_in_ready        = r_in_ready;
  assign o_out_valid       = r_main_valid;
  assign o_out_pc          = r_main.pc;
  assign o_out_rs1         = r_main.rs1;
  assign o_out_rs2         = r_main.rs2;
  assign o_out_rd          = r_main.rd;
  assign o_out_imm         = r_main.imm;
  assign o_out_alu_op      = r_main.alu_op;
  assign o_out_src1_pc     = r_main.src1_pc;
  assign o_out_src2_imm    = r_main.src2_imm;
  assign o_out_pc_op       = r_main.pc_op;
  assign o_out_wd_op       = r_main.wd_op;
  assign o_out_mem_ren     = r_main.mem_ren;
  assign o_out_mem_wen     = r_main.mem_wen;
  assign o_out_mem_size    = r_main.mem_size;
  assign o_out_load_signed = r_main.load_signed;
  assign o_out_rf_wen      = r_main.rf_wen;
  assign o_out_csr_wen     = r_main.csr_wen;
  assign o_out_csr_idx     = r_main.csr_idx;
  assign o_out_ecall       = r_main.ecall;
  assign o_out_mret        = r_main.mret;
  assign o_out_ebreak      = r_main.ebreak;
  assign o_out_illegal     = r_main.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: hand-computed decode table, handshake
// corner sequences, an XLEN=64 instance, and randomized traffic against a
// queue-based reference model.
module tb_idu_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic        out_src1_pc, out_src2_imm, out_mem_ren, out_mem_wen, out_load_signed;
  logic        out_rf_wen, out_csr_wen, out_ecall, out_mret, out_ebreak, out_illegal;
  logic [1:0]  out_pc_op, out_wd_op, out_mem_size, out_csr_idx;

  logic        v64, ordy64, in_ready64, out_valid64;
  logic [31:0] inst64;
  logic [63:0] pc64, out_pc64, out_imm64;
  logic [4:0]  rs1_64, rs2_64, rd_64, alu64;
  logic        s1pc64, s2imm64, ren64, wen64, lsgn64, rfw64, csrw64, ecall64, mret64, ebreak64, ill64;
  logic [1:0]  pcop64, wdop64, msize64, csridx64;

  idu_stage #(.XLEN(32), .ALUOP_W(5), .CSR_IDX_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_inst(in_inst), .i_in_pc(in_pc), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_rd(out_rd),
    .o_out_imm(out_imm), .o_out_alu_op(out_alu_op), .o_out_src1_pc(out_src1_pc),
    .o_out_src2_imm(out_src2_imm), .o_out_pc_op(out_pc_op), .o_out_wd_op(out_wd_op),
    .o_out_mem_ren(out_mem_ren), .o_out_mem_wen(out_mem_wen), .o_out_mem_size(out_mem_size),
    .o_out_load_signed(out_load_signed), .o_out_rf_wen(out_rf_wen), .o_out_csr_wen(out_csr_wen),
    .o_out_csr_idx(out_csr_idx), .o_out_ecall(out_ecall), .o_out_mret(out_mret),
    .o_out_ebreak(out_ebreak), .o_out_illegal(out_illegal));

  idu_stage #(.XLEN(64), .ALUOP_W(5), .CSR_IDX_W(2)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_in_valid(v64), .o_in_ready(in_ready64),
    .i_in_inst(inst64), .i_in_pc(pc64), .o_out_valid(out_valid64), .i_out_ready(ordy64),
    .o_out_pc(out_pc64), .o_out_rs1(rs1_64), .o_out_rs2(rs2_64), .o_out_rd(rd_64),
    .o_out_imm(out_imm64), .o_out_alu_op(alu64), .o_out_src1_pc(s1pc64),
    .o_out_src2_imm(s2imm64), .o_out_pc_op(pcop64), .o_out_wd_op(wdop64),
    .o_out_mem_ren(ren64), .o_out_mem_wen(wen64), .o_out_mem_size(msize64),
    .o_out_load_signed(lsgn64), .o_out_rf_wen(rfw64), .o_out_csr_wen(csrw64),
    .o_out_csr_idx(csridx64), .o_out_ecall(ecall64), .o_out_mret(mret64),
    .o_out_ebreak(ebreak64), .o_out_illegal(ill64));

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        s1pc, s2imm;
    logic [1:0]  pc_op, wd_op;
    logic        ren, wen;
    logic [1:0]  msize;
    logic        lsgn, rf_wen, csr_wen;
    logic [1:0]  csr_idx;
    logic        ecall, mret, ebreak, illegal;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rf_wen, s2imm;
    logic [1:0]  pc_op, wd_op;
    logic        csr_wen;
    logic [1:0]  csr_idx;
    logic        ren, wen, ill, ecall, mret, ebreak;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] q[$];   // {pc, inst} of accepted, not yet delivered instructions

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dec_t act_dec();
    return {out_imm, out_alu_op, out_src1_pc, out_src2_imm, out_pc_op, out_wd_op, out_mem_ren,
            out_mem_wen, out_mem_size, out_load_signed, out_rf_wen, out_csr_wen, out_csr_idx,
            out_ecall, out_mret, out_ebreak, out_illegal};
  endfunction

  // Reference decode written from the ISA rules with integer arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t e = '0;
    int   base_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   br_tab[8]   = '{19, 20, 0, 0, 3, 21, 4, 22};
    int   csr_addr[4] = '{'h342, 'h341, 'h300, 'h305};
    int   f3 = int'(w[14:12]);
    int   f7 = int'(w[31:25]);
    int   ii, is, ib, ij, iu;
    logic ok = 1'b1, wr = 1'b0;
    ii = (w[31] ? -2048 : 0) + int'(w[30:20]);
    is = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
    ib = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    ij = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    iu = int'(w & 32'hFFFF_F000);
    case (w[6:0])
      7'h37: begin e.imm = iu; e.alu = 18; e.s2imm = 1; wr = 1; end
      7'h17: begin e.imm = iu; e.s1pc = 1; e.s2imm = 1; wr = 1; end
      7'h6F: begin e.imm = ij; e.s1pc = 1; e.s2imm = 1; e.pc_op = 1; e.wd_op = 2; wr = 1; end
      7'h67: begin e.imm = ii; e.s2imm = 1; e.pc_op = 2; e.wd_op = 2; wr = 1; end
      7'h63: begin e.imm = ib; e.alu = 5'(br_tab[f3]); e.pc_op = 1; end
      7'h03: begin e.imm = ii; e.s2imm = 1; e.wd_op = 1; e.ren = 1; wr = 1; end
      7'h23: begin e.imm = is; e.s2imm = 1; e.wen = 1; end
      7'h13: begin
        e.imm = ii; e.s2imm = 1; wr = 1;
        e.alu = (f3 == 5 && w[30]) ? 5'd7 : 5'(base_tab[f3]);
      end
      7'h33: begin
        wr = 1;
        if (f7 == 1) e.alu = 5'(10 + f3);
        else if (f7 == 0) e.alu = 5'(base_tab[f3]);
        else if (f7 == 'h20 && f3 == 0) e.alu = 1;
        else if (f7 == 'h20 && f3 == 5) e.alu = 7;
        else ok = 0;
      end
      7'h73: begin
        e.imm = {20'h0, w[31:20]};
        if (w == 32'h73) begin e.ecall = 1; e.csr_wen = 1; e.csr_idx = 3; e.pc_op = 3; end
        else if (w == 32'h3020_0073) begin e.mret = 1; e.csr_idx = 1; e.pc_op = 3; end
        else if (w == 32'h0010_0073) e.ebreak = 1;
        else if (f3 == 1 || f3 == 2) begin
          e.alu = (f3 == 1) ? 5'd23 : 5'd8; e.wd_op = 3; e.csr_wen = 1; wr = 1; ok = 0;
          for (int k = 0; k < 4; k++)
            if (int'(w[31:20]) == csr_addr[k]) begin ok = 1; e.csr_idx = 2'(k); end
        end else ok = 0;
      end
      default: ok = 0;
    endcase
    e.lsgn   = !w[14];
    e.msize  = ok ? w[13:12] : 2'd0;
    e.rf_wen = ok && wr && (w[11:7] != 0);
    if (!ok) begin
      e.illegal = 1; e.ren = 0; e.wen = 0; e.csr_wen = 0; e.pc_op = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w = $urandom;
    logic [6:0]  ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [11:0] csrs[4] = '{12'h342, 12'h341, 12'h300, 12'h305};
    int k = int'($urandom_range(0, 11));
    if (k < 10) w[6:0] = ops[k];
    if (w[6:0] == 7'h33)
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    if (w[6:0] == 7'h73)
      case ($urandom_range(0, 5))
        0: w = 32'h0000_0073;
        1: w = 32'h3020_0073;
        2: w = 32'h0010_0073;
        3, 4: begin w[31:20] = csrs[$urandom_range(0, 3)]; w[14:12] = 3'($urandom_range(1, 2)); end
        default: ;
      endcase
    return w;
  endfunction

  // Drive one cycle, check the visible state against the model, advance model at the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic do_out, do_in;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("pc_regs", {out_pc, out_rs1, out_rs2, out_rd},
          {q[0][63:32], q[0][19:15], q[0][24:20], q[0][11:7]});
      chk("bundle", act_dec(), ref_dec(q[0][31:0]));
    end
    do_out = (q.size() > 0) && ordy;
    do_in  = v && (q.size() < 2);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back({pc, inst});
    end
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h305312F3, 32'h00000305, 5'd5,  1, 0, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h00000073, 32'h00000000, 5'd0,  0, 0, 3, 0, 1, 3, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{32'h30200073, 32'h00000302, 5'd0,  0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{32'h00100073, 32'h00000001, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000000, 5'd31, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{32'h800001B7, 32'h80000000, 5'd3,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{32'hFE20AE23, 32'hFFFFFFFC, 5'd28, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 5'd1,  1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h343312F3, 32'h00000343, 5'd5,  0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{32'h40001033, 32'h00000000, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{32'h00812203, 32'h00000008, 5'd4,  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h00500013, 32'h00000005, 5'd0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    v64 = 1'b0; inst64 = '0; pc64 = '0; ordy64 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bundle", {act_dec(), out_pc, out_rs1, out_rs2, out_rd}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hand-computed decode table, one instruction per cycle.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, vecs[i].inst, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("vec%0d_ctl", i),
          {out_rd, out_rf_wen, out_src2_imm, out_pc_op, out_wd_op, out_csr_wen, out_csr_idx,
           out_mem_ren, out_mem_wen, out_illegal, out_ecall, out_mret, out_ebreak},
          {vecs[i].rd, vecs[i].rf_wen, vecs[i].s2imm, vecs[i].pc_op, vecs[i].wd_op,
           vecs[i].csr_wen, vecs[i].csr_idx, vecs[i].ren, vecs[i].wen, vecs[i].ill,
           vecs[i].ecall, vecs[i].mret, vecs[i].ebreak});
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Back-to-back stream of 8 at full throughput.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00000093 | (32'(i) << 20), 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall: two accepted, third held off, then drain in order.
    step(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h104, 1'b0, 1'b0);
    chk("skid_in_ready_low", in_ready, 1'b0);
    chk("stall_head_pc", out_pc, 32'h100);
    step(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall_hold_imm", out_imm, 32'h1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain_in_ready_back", in_ready, 1'b1);
    chk("drain_second_pc", out_pc, 32'h104);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with both entries full and a new instruction offered.
    step(1'b1, 32'h00400213, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h208, 1'b0, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-transfer discards both entries.
    step(1'b1, 32'h00700393, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 32'h304, 1'b0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    q.delete();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_pc", out_pc, 32'h0);

    // XLEN=64 build: jal x1,-4.
    v64 = 1'b1; inst64 = 32'hFFDFF0EF; pc64 = 64'h0000_0001_0000_0000; ordy64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    chk("x64_valid", out_valid64, 1'b1);
    chk("x64_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("x64_pc", out_pc64, 64'h0000_0001_0000_0000);
    chk("x64_ctl", {pcop64, wdop64, rfw64, rd_64}, {2'd1, 2'd2, 1'b1, 5'd1});

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
